// File: rtl/cpu_clk_ctrl.sv
// Run/halt/step/burst sequencer issuing a one-cycle CPU clock enable on the board clock.
// Optional STEP_DEBOUNCE_EN adds a synchronizer and debouncer in front of the step button.
module cpu_clk_ctrl #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned DEFAULT_DIV     = 50000000,
  parameter int unsigned BURST_W         = 16,
  parameter int unsigned CYC_W           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               cmd_run,
  input  logic               cmd_halt,
  input  logic               cmd_burst,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cmd_step,
  output logic               cpu_ce,
  output logic               busy,
  output logic [1:0]         state,
  output logic [CYC_W-1:0]   ce_count,
  output logic [CNT_W-1:0]   div_cfg
);

  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StRun   = 2'b01,
    StStep  = 2'b10,
    StBurst = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [CYC_W-1:0]   count_q;
  logic               ce_q, ce_d;
  logic               step_prev_q;
  logic               step_lvl;
  logic               step_edge;
  logic               running;
  logic               tick;

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  logic           sync1_q, sync2_q, db_lvl_q;
  logic [DbW-1:0] db_cnt_q;

  // Level flips only after the synchronized input has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync1_q  <= cmd_step;
      sync2_q  <= cmd_step;
      db_lvl_q <= cmd_step;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= cmd_step;
      sync2_q <= sync1_q;
      if (sync2_q != db_lvl_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl_q <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign step_lvl = db_lvl_q;
`else
  assign step_lvl = cmd_step;

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
  end
`endif

  assign running   = (state_q == StRun) || (state_q == StBurst);
  assign tick      = running && !cfg_we && (cnt_q == div_q - CNT_W'(1));
  assign step_edge = step_lvl & ~step_prev_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ce_d    = 1'b0;
    div_d   = div_q;
    cnt_d   = running ? (tick ? '0 : cnt_q + CNT_W'(1)) : '0;
    if (cfg_we) begin
      div_d = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    end

    unique case (state_q)
      StHalt: begin
        if (cmd_halt) begin
          state_d = StHalt;
        end else if (cmd_run) begin
          state_d = StRun;
        end else if (cmd_burst) begin
          if (burst_len != '0) begin
            state_d = StBurst;
            rem_d   = burst_len;
          end
        end else if (step_edge) begin
          state_d = StStep;
        end
      end
      StStep: begin
        ce_d    = 1'b1;
        state_d = StHalt;
      end
      StRun: begin
        if (cmd_halt) begin
          state_d = StHalt;
        end else if (cmd_burst && !cmd_run) begin
          cnt_d = '0;
          if (burst_len != '0) begin
            state_d = StBurst;
            rem_d   = burst_len;
          end else begin
            state_d = StHalt;
          end
        end else begin
          ce_d = tick;
        end
      end
      StBurst: begin
        if (cmd_halt) begin
          state_d = StHalt;
          rem_d   = '0;
        end else if (cmd_run) begin
          state_d = StRun;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (cmd_burst) begin
          cnt_d = '0;
          if (burst_len != '0) begin
            rem_d = burst_len;
          end else begin
            state_d = StHalt;
            rem_d   = '0;
          end
        end else if (tick) begin
          ce_d  = 1'b1;
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = StHalt;
          end
        end
      end
    endcase

    // Divider only runs in RUN/BURST; a config write always restarts the period.
    if (state_d == StHalt || state_d == StStep || cfg_we) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q     <= StHalt;
      cnt_q       <= '0;
      div_q       <= CNT_W'(DEFAULT_DIV);
      rem_q       <= '0;
      ce_q        <= 1'b0;
      count_q     <= '0;
      step_prev_q <= step_lvl;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      ce_q        <= ce_d;
      count_q     <= count_q + CYC_W'(ce_d);
      step_prev_q <= step_lvl;
    end
  end

  assign cpu_ce   = ce_q;
  assign busy     = running;
  assign state    = state_q;
  assign ce_count = count_q;
  assign div_cfg  = div_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl (DEFAULT_DIV=4, DEBOUNCE_CYCLES=8).
module tb_cpu_clk_ctrl;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned BURST_W = 16;
  localparam int unsigned CYC_W   = 32;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               cfg_we;
  logic [CNT_W-1:0]   cfg_div;
  logic               cmd_run;
  logic               cmd_halt;
  logic               cmd_burst;
  logic [BURST_W-1:0] burst_len;
  logic               cmd_step;
  logic               cpu_ce;
  logic               busy;
  logic [1:0]         state;
  logic [CYC_W-1:0]   ce_count;
  logic [CNT_W-1:0]   div_cfg;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int acc    = 0;

  cpu_clk_ctrl #(
    .CNT_W          (CNT_W),
    .DEFAULT_DIV    (4),
    .BURST_W        (BURST_W),
    .CYC_W          (CYC_W),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_div  (cfg_div),
    .cmd_run  (cmd_run),
    .cmd_halt (cmd_halt),
    .cmd_burst(cmd_burst),
    .burst_len(burst_len),
    .cmd_step (cmd_step),
    .cpu_ce   (cpu_ce),
    .busy     (busy),
    .state    (state),
    .ce_count (ce_count),
    .div_cfg  (div_cfg)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_cycles(input int n);
    pulses = 0;
    repeat (n) begin
      @(negedge clk_in);
      if (cpu_ce) pulses++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_div = '0; cmd_run = 1'b0; cmd_halt = 1'b0;
    cmd_burst = 1'b0; burst_len = '0; cmd_step = 1'b0;
    repeat (3) @(negedge clk_in);

    // Reset state and idle
    check("rst_state", 64'(state), 0);
    check("rst_ce", 64'(cpu_ce), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_count", 64'(ce_count), 0);
    check("rst_div", 64'(div_cfg), 4);
    reset = 1'b1;
    run_cycles(20);
    check("idle_pulses", 64'(pulses), 0);
    check("idle_state", 64'(state), 0);
    check("idle_count", 64'(ce_count), 0);

    // RUN at div 4, then halt
    cmd_run = 1'b1; @(negedge clk_in); cmd_run = 1'b0;
    check("run_state", 64'(state), 1);
    check("run_busy", 64'(busy), 1);
    run_cycles(16);
    check("run_pulses", 64'(pulses), 4);
    check("run_count", 64'(ce_count), 4);
    cmd_halt = 1'b1; @(negedge clk_in); cmd_halt = 1'b0;
    check("halt_state", 64'(state), 0);
    check("halt_busy", 64'(busy), 0);
    run_cycles(8);
    check("halt_pulses", 64'(pulses), 0);
    check("halt_count", 64'(ce_count), 4);

    // Divide-ratio writes during RUN
    cmd_run = 1'b1; @(negedge clk_in); cmd_run = 1'b0;
    run_cycles(2);
    cfg_we = 1'b1; cfg_div = '0; @(negedge clk_in); cfg_we = 1'b0;
    check("div0_div", 64'(div_cfg), 1);
    check("div0_first_ce", 64'(cpu_ce), 0);
    run_cycles(6);
    check("div1_pulses", 64'(pulses), 6);
    check("div1_count", 64'(ce_count), 10);
    cfg_we = 1'b1; cfg_div = 3; @(negedge clk_in); cfg_we = 1'b0;
    check("div3_ce", 64'(cpu_ce), 0);
    check("div3_div", 64'(div_cfg), 3);
    run_cycles(9);
    check("div3_pulses", 64'(pulses), 3);
    check("div3_count", 64'(ce_count), 13);
    cmd_halt = 1'b1; @(negedge clk_in); cmd_halt = 1'b0;
    check("div3_halt", 64'(state), 0);

    // Bursts at div 2
    cfg_we = 1'b1; cfg_div = 2; @(negedge clk_in); cfg_we = 1'b0;
    cmd_burst = 1'b1; burst_len = 5; @(negedge clk_in); cmd_burst = 1'b0;
    check("burst_state", 64'(state), 3);
    check("burst_busy", 64'(busy), 1);
    run_cycles(12);
    check("burst_pulses", 64'(pulses), 5);
    check("burst_end_state", 64'(state), 0);
    check("burst_end_busy", 64'(busy), 0);
    check("burst_count", 64'(ce_count), 18);
    cmd_burst = 1'b1; burst_len = 0; @(negedge clk_in); cmd_burst = 1'b0;
    check("burst0_state", 64'(state), 0);
    run_cycles(4);
    check("burst0_pulses", 64'(pulses), 0);

    // Single step
`ifdef STEP_DEBOUNCE_EN
    cmd_step = 1'b1; run_cycles(5); acc = pulses;
    cmd_step = 1'b0; run_cycles(20); acc += pulses;
    check("glitch_pulses", 64'(acc), 0);
    cmd_step = 1'b1; run_cycles(10); acc = pulses;
    cmd_step = 1'b0; run_cycles(30); acc += pulses;
    check("press_pulses", 64'(acc), 1);
`else
    cmd_step = 1'b1; @(negedge clk_in);
    check("step_state", 64'(state), 2);
    check("step_ce_early", 64'(cpu_ce), 0);
    @(negedge clk_in);
    check("step_ce", 64'(cpu_ce), 1);
    check("step_back", 64'(state), 0);
    run_cycles(6);
    check("step_held", 64'(pulses), 0);
    cmd_step = 1'b0; run_cycles(2);
`endif
    check("step_count", 64'(ce_count), 19);

    // Step edges while running are dropped
    cmd_run = 1'b1; cmd_step = 1'b1; @(negedge clk_in); cmd_run = 1'b0;
    check("runstep_state", 64'(state), 1);
    run_cycles(16);
    check("runstep_pulses", 64'(pulses), 8);
    cmd_halt = 1'b1; @(negedge clk_in); cmd_halt = 1'b0;
    run_cycles(4);
    check("runstep_after", 64'(pulses), 0);
    cmd_step = 1'b0; run_cycles(12);
    check("runstep_release", 64'(pulses), 0);
    check("runstep_count", 64'(ce_count), 27);

    // Reset in the middle of a burst (rem=3 after two enables)
    cmd_burst = 1'b1; burst_len = 5; @(negedge clk_in); cmd_burst = 1'b0;
    run_cycles(4);
    check("mid_pulses", 64'(pulses), 2);
    check("mid_ce", 64'(cpu_ce), 1);
    check("mid_count", 64'(ce_count), 29);
    reset = 1'b0; @(negedge clk_in);
    check("mrst_state", 64'(state), 0);
    check("mrst_ce", 64'(cpu_ce), 0);
    check("mrst_busy", 64'(busy), 0);
    check("mrst_count", 64'(ce_count), 0);
    check("mrst_div", 64'(div_cfg), 4);
    reset = 1'b1; @(negedge clk_in);

    // Halt wins over run
    cmd_run = 1'b1; @(negedge clk_in); cmd_run = 1'b0;
    check("prio_run", 64'(state), 1);
    cmd_halt = 1'b1; cmd_run = 1'b1; @(negedge clk_in);
    cmd_halt = 1'b0; cmd_run = 1'b0;
    check("prio_halt", 64'(state), 0);
    run_cycles(8);
    check("prio_pulses", 64'(pulses), 0);
    check("prio_count", 64'(ce_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Run/halt/step/burst controller for the CPU clock on the FPGA board. It replaces free-running toggled slow clocks with a single-cycle clock-enable pulse (cpu_ce) on the fast board clock. The CPU datapath and register file qualify their updates with cpu_ce.
- Sits between the board buttons/switches (or a debug UART) and the core.
- Owns the programmable divide ratio and sequences how many enables the core receives.

Parameters:
CNT_W, 32, width of the divider counter and divide-ratio register
DEFAULT_DIV, 50000000, divide ratio loaded at reset (clk_in cycles per cpu_ce in RUN/BURST)
BURST_W, 16, width of burst length
CYC_W, 32, width of the issued-enable counter
DEBOUNCE_CYCLES, 1000000, stable-level requirement for cmd_step when STEP_DEBOUNCE_EN is defined

Ports:
clk_in  in  1  board clock; all logic on rising edge
reset  in  1  synchronous, active-low reset; asserted when reset==0 at a clk_in edge
cfg_we  in  1  one-cycle strobe: load cfg_div into divide-ratio register
cfg_div  in  CNT_W  new divide ratio; 0 is treated as 1
cmd_run  in  1  one-cycle strobe: enter RUN
cmd_halt  in  1  one-cycle strobe: enter HALT
cmd_burst  in  1  one-cycle strobe: start a burst of burst_len enables
burst_len  in  BURST_W  burst length sampled with cmd_burst
cmd_step  in  1  step button level; a rising edge requests one enable
cpu_ce  out  1  registered one-cycle clock enable to the core
busy  out  1  1 in RUN or BURST
state  out  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
ce_count  out  CYC_W  total cpu_ce pulses issued since reset; wraps modulo 2^CYC_W
div_cfg  out  CNT_W  current divide ratio, for readback

Behaviour:
Reset (reset==0 at edge):
- state=HALT, cpu_ce=0, busy=0, ce_count=0, div_cfg=DEFAULT_DIV.
- Divider counter=0, burst remainder=0, step edge register=current cmd_step level (no spurious step after reset).

Divider:
- Counter cnt runs 0..div_cfg-1 only in RUN/BURST; held at 0 in HALT/STEP.
- tick = (cnt==div_cfg-1); cnt wraps to 0 on tick.
- cfg_we: div_cfg<=max(cfg_div,1); cnt<=0 in the same cycle; no tick is issued that cycle. Allowed in any state.

Output timing:
- cpu_ce is registered: it asserts in the cycle after the tick/step decision and is high exactly 1 cycle.
- With div_cfg=1 in RUN, cpu_ce is high continuously.
- ce_count increments in the same cycle cpu_ce is high.

FSM, commands evaluated each cycle, priority halt > run > burst > step:
- HALT:
  - cmd_run -> RUN (cnt=0).
  - cmd_burst with burst_len!=0 -> BURST (rem=burst_len, cnt=0).
  - cmd_burst with burst_len==0 -> stays HALT, no enable.
  - Step rising edge -> STEP.
- STEP: issues one cpu_ce, returns to HALT next cycle. Commands arriving in the STEP cycle are ignored except cmd_halt (no-op).
- RUN:
  - tick -> cpu_ce.
  - cmd_halt -> HALT; a tick in the same cycle is suppressed.
  - cmd_burst -> BURST (rem=burst_len, cnt=0); burst_len==0 -> HALT.
  - Step edges ignored.
- BURST:
  - tick -> cpu_ce and rem-1; when rem reaches 0 -> HALT in the same cycle the last cpu_ce is scheduled.
  - cmd_halt aborts -> HALT and clears rem.
  - cmd_run -> RUN and discards rem.
  - A new cmd_burst reloads rem and cnt=0.
  - Step edges ignored.

Step edge detection:
- Edge = level & ~prev.
- Edges outside HALT are dropped, not queued.
- A step held high produces one step only.

Reset mid-operation: aborts any RUN/BURST immediately; a pending registered cpu_ce is cleared.

Optional Feature:
STEP_DEBOUNCE_EN:
- Defined: cmd_step passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive clk_in cycles; the edge detector uses the debounced level. The debouncer counter is reset to 0 and the level is preset from cmd_step at reset.
- Undefined: cmd_step is used directly (caller guarantees a clean, synchronous level); step latency is input rise -> STEP state next edge -> cpu_ce the following cycle.

Test Plan:
1. Reset then idle, DEFAULT_DIV=4, 20 cycles -> cpu_ce never high, state=00, ce_count=0, div_cfg=4.
2. cmd_run, then 16 cycles with div_cfg=4 -> cpu_ce high every 4th cycle (4 pulses), ce_count=4, busy=1; cmd_halt -> state=00, no further pulses.
3. cfg_we with cfg_div=0 during RUN -> div_cfg=1, cnt cleared, cpu_ce high every cycle from the second cycle onward; cfg_div=3 -> period 3.
4. cmd_burst with burst_len=5, div_cfg=2 -> exactly 5 cpu_ce pulses 2 cycles apart, then state=00, busy=0; burst_len=0 -> no pulse, stays HALT.
5. Raise and hold cmd_step in HALT (debounce off) -> exactly one cpu_ce, ce_count+1. A step edge during RUN -> no extra pulse. With STEP_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle glitch -> no pulse; a 10-cycle press -> one pulse.
6. reset driven low mid-BURST (rem=3) -> next cycle state=00, cpu_ce=0, ce_count=0, div_cfg=DEFAULT_DIV; simultaneous cmd_halt+cmd_run -> HALT wins.
